fpu_round_sched: RTL and testbench

FPU_ROUND_SCHED -- requirements
Module: fpu_round_sched

---
 rtl/fpu_pkg.sv | 73 +++++++
 rtl/fpu_round_core.sv | 43 ++++
 rtl/fpu_round_sched.sv | 140 ++++++++++++++
 tb/tb_fpu_round_sched.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU rounding types: field widths, rounding modes, operand/result payloads
// and the single-operand rounding function used by the rounding core.
package fpu_pkg;

  localparam int unsigned MANT_W = 23;
  localparam int unsigned EXP_W  = 8;
  localparam int unsigned NORM_W = 28;
  localparam int unsigned SUM_W  = 25;
  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rmode_e;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } src_e;

  typedef struct packed {
    logic              src;
    logic              sign;
    logic [MODE_W-1:0] mode;
    logic [EXP_W-1:0]  exp;
    logic [NORM_W-1:0] mant;
  } rnd_op_t;

  typedef struct packed {
    logic              src;
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
  } rnd_res_t;

  // mant[27:3] is the kept field, mant[2:0] are guard/round/sticky.
  function automatic rnd_res_t round_op(rnd_op_t op);
    logic             g;
    logic             r;
    logic             s;
    logic             lsb;
    logic             inexact;
    logic             inc;
    logic [SUM_W-1:0] sum;
    rnd_res_t         res;
    g       = op.mant[2];
    r       = op.mant[1];
    s       = op.mant[0];
    lsb     = op.mant[3];
    inexact = g | r | s;
    inc     = 1'b0;
    case (rmode_e'(op.mode))
      RM_RNE:  inc = g & (r | s | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~op.sign & inexact;
      RM_RDN:  inc = op.sign & inexact;
      default: inc = 1'b0;
    endcase
    sum      = op.mant[NORM_W-1:3] + SUM_W'(inc);
    res.src  = op.src;
    res.sign = op.sign;
    res.exp  = op.exp;
    if (sum[SUM_W-1]) begin
      sum     = sum >> 1;
      res.exp = (op.exp == '1) ? op.exp : op.exp + EXP_W'(1);
    end
    res.mant = sum[MANT_W-1:0];
    return res;
  endfunction

endpackage

// File: rtl/fpu_round_core.sv
// Shared rounding pipeline: one operand per cycle, fixed ROUND_LAT latency, never stalls.
module fpu_round_core
  import fpu_pkg::*;
#(
  parameter int unsigned ROUND_LAT = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     in_valid,
  input  rnd_op_t  in_op,
  output logic     out_valid,
  output rnd_res_t out_res
);

  logic [ROUND_LAT-1:0] vld;
  rnd_res_t             pipe [ROUND_LAT];
  rnd_res_t             res_c;

  assign res_c = round_op(in_op);

  // Valid shift chain; only this needs clearing on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else begin
      vld[0] <= in_valid;
      for (int unsigned i = 1; i < ROUND_LAT; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    pipe[0] <= res_c;
    for (int unsigned i = 1; i < ROUND_LAT; i++) begin
      pipe[i] <= pipe[i-1];
    end
  end

  assign out_valid = vld[ROUND_LAT-1];
  assign out_res   = pipe[ROUND_LAT-1];

endmodule

// File: rtl/fpu_round_sched.sv
// Round-robin scheduler sharing one rounding core between the adder (A) and
// multiplier (B) paths, with a credit-guarded result FIFO.
module fpu_round_sched
  import fpu_pkg::*;
#(
  parameter int unsigned ROUND_LAT  = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        a_valid,
  output logic                        a_ready,
  input  logic [NORM_W-1:0]           a_mant,
  input  logic [EXP_W-1:0]            a_exp,
  input  logic                        a_sign,
  input  logic [MODE_W-1:0]           a_mode,
  input  logic                        b_valid,
  output logic                        b_ready,
  input  logic [NORM_W-1:0]           b_mant,
  input  logic [EXP_W-1:0]            b_exp,
  input  logic                        b_sign,
  input  logic [MODE_W-1:0]           b_mode,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [MANT_W-1:0]           out_mant,
  output logic [EXP_W-1:0]            out_exp,
  output logic                        out_sign,
  output logic                        out_src,
  output logic [$clog2(FIFO_DEPTH):0] occupancy
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PTR_W = AW + 1;
  localparam int unsigned OCC_W = AW + 1;

  src_e       last_grant;
  logic       run;
  logic       credit;
  logic       fire;
  logic       pop;
  rnd_op_t    op_c;
  logic       core_valid;
  rnd_res_t   core_res;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  rnd_res_t   mem [FIFO_DEPTH];
  rnd_res_t   head;

  // Occupancy counts in-flight plus buffered results, so a free credit
  // guarantees a FIFO slot when the result lands.
  assign credit = run && (occupancy < OCC_W'(FIFO_DEPTH));

  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (credit) begin
      if (a_valid && b_valid) begin
        if (last_grant == SRC_B) a_ready = 1'b1;
        else                     b_ready = 1'b1;
      end else begin
        a_ready = a_valid;
        b_ready = b_valid;
      end
    end
  end

  assign fire = a_ready | b_ready;
  assign pop  = out_valid & out_ready;

  always_comb begin
    op_c.src  = SRC_A;
    op_c.sign = a_sign;
    op_c.mode = a_mode;
    op_c.exp  = a_exp;
    op_c.mant = a_mant;
    if (b_ready) begin
      op_c.src  = SRC_B;
      op_c.sign = b_sign;
      op_c.mode = b_mode;
      op_c.exp  = b_exp;
      op_c.mant = b_mant;
    end
  end

  fpu_round_core #(
    .ROUND_LAT(ROUND_LAT)
  ) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (fire),
    .in_op    (op_c),
    .out_valid(core_valid),
    .out_res  (core_res)
  );

  // Arbitration state; grants stay off for the first cycle after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run        <= 1'b0;
      last_grant <= SRC_B;
      occupancy  <= '0;
    end else begin
      run <= 1'b1;
      if (a_ready)      last_grant <= SRC_A;
      else if (b_ready) last_grant <= SRC_B;
      case ({fire, pop})
        2'b10:   occupancy <= occupancy + OCC_W'(1);
        2'b01:   occupancy <= occupancy - OCC_W'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  // Result FIFO; pointers carry an extra wrap bit for full/empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (core_valid) begin
        mem[wr_ptr[AW-1:0]] <= core_res;
        wr_ptr              <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign head      = mem[rd_ptr[AW-1:0]];
  assign out_valid = (wr_ptr != rd_ptr);
  assign out_mant  = head.mant;
  assign out_exp   = head.exp;
  assign out_sign  = head.sign;
  assign out_src   = head.src;

endmodule

// File: tb/tb_fpu_round_sched.sv
// Scoreboard bench for fpu_round_sched: directed scenarios plus random traffic,
// expected results from an arithmetic rounding model.
module tb_fpu_round_sched;
  import fpu_pkg::*;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [27:0] a_mant = '0, b_mant = '0;
  logic [7:0]  a_exp = '0, b_exp = '0;
  logic        a_sign = 1'b0, b_sign = 1'b0;
  logic [1:0]  a_mode = '0, b_mode = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [22:0] out_mant;
  logic [7:0]  out_exp;
  logic        out_sign, out_src;
  logic [$clog2(DEPTH):0] occupancy;

  fpu_round_sched #(.ROUND_LAT(LAT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_mant(a_mant), .a_exp(a_exp),
    .a_sign(a_sign), .a_mode(a_mode),
    .b_valid(b_valid), .b_ready(b_ready), .b_mant(b_mant), .b_exp(b_exp),
    .b_sign(b_sign), .b_mode(b_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_mant(out_mant),
    .out_exp(out_exp), .out_sign(out_sign), .out_src(out_src),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [22:0] mant;
    logic [7:0]  exp;
    logic        sign;
    logic        src;
    int          cyc;
  } exp_t;

  exp_t sbq[$];
  logic grant_log[$];
  logic src_log[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   tb_occ = 0;
  logic tb_last = 1'b1;
  bit   lat_chk = 1'b0;
  bit   rec_on = 1'b0;
  logic exp_a, exp_b;
  logic a_fire, b_fire, popped;
  exp_t e;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  // Reference rounding: integer arithmetic on the kept field.
  function automatic exp_t model(input logic [27:0] m, input logic [7:0] ex,
                                 input logic s, input logic [1:0] md, input logic src);
    exp_t        r;
    int unsigned field;
    int unsigned e_i;
    bit          g, rb, st, odd, up;
    field = int'(m) / 8;
    g  = m[2]; rb = m[1]; st = m[0]; odd = m[3];
    up = 1'b0;
    if (md == 2'd0) up = g && (rb || st || odd);
    else if (md == 2'd2) up = !s && (g || rb || st);
    else if (md == 2'd3) up = s && (g || rb || st);
    if (up) field = field + 1;
    e_i = int'(ex);
    if (field >= 32'h0100_0000) begin
      field = field / 2;
      if (e_i < 255) e_i = e_i + 1;
    end
    r.mant = 23'(field % 32'h0080_0000);
    r.exp  = 8'(e_i);
    r.sign = s;
    r.src  = src;
    r.cyc  = 0;
    return r;
  endfunction

  // Monitor: grant/occupancy model, scoreboard push on transfer, pop and compare on output.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("occupancy", 32'(occupancy), 32'(tb_occ));
      exp_a = 1'b0;
      exp_b = 1'b0;
      if (tb_occ < int'(DEPTH)) begin
        if (a_valid && b_valid) begin
          if (tb_last) exp_a = 1'b1;
          else         exp_b = 1'b1;
        end else begin
          exp_a = a_valid;
          exp_b = b_valid;
        end
      end
      chk("grant", 32'({a_ready, b_ready}), 32'({exp_a, exp_b}));
      a_fire = a_valid && a_ready;
      b_fire = b_valid && b_ready;
      if (a_fire) begin
        e = model(a_mant, a_exp, a_sign, a_mode, 1'b0);
        e.cyc = cyc;
        sbq.push_back(e);
      end else if (b_fire) begin
        e = model(b_mant, b_exp, b_sign, b_mode, 1'b1);
        e.cyc = cyc;
        sbq.push_back(e);
      end
      if (rec_on && (a_fire || b_fire)) grant_log.push_back(b_fire);
      popped = out_valid && out_ready;
      if (popped) begin
        if (sbq.size() == 0) begin
          chk("spurious_out_valid", 32'(out_valid), 32'(0));
        end else begin
          e = sbq.pop_front();
          chk("out_mant", 32'(out_mant), 32'(e.mant));
          chk("out_exp", 32'(out_exp), 32'(e.exp));
          chk("out_sign", 32'(out_sign), 32'(e.sign));
          chk("out_src", 32'(out_src), 32'(e.src));
          if (lat_chk) chk("latency", 32'(cyc - e.cyc), 32'(LAT + 1));
          if (rec_on) src_log.push_back(out_src);
        end
      end
      tb_occ = tb_occ + ((a_fire || b_fire) ? 1 : 0) - (popped ? 1 : 0);
      if (a_fire) tb_last = 1'b0;
      else if (b_fire) tb_last = 1'b1;
    end
  end

  function automatic logic [27:0] rnd_mant();
    logic [27:0] m;
    m = {2'b01, 26'($urandom)};
    if ($urandom_range(5) == 0) m[26:3] = '1;
    return m;
  endfunction

  task automatic rand_ops();
    a_mant = rnd_mant(); b_mant = rnd_mant();
    a_exp  = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
    b_exp  = ($urandom_range(7) == 0) ? 8'hFF : 8'($urandom);
    a_sign = 1'($urandom); b_sign = 1'($urandom);
    a_mode = 2'($urandom); b_mode = 2'($urandom);
  endtask

  // Called just after a rising edge; checks the reset state and releases cleanly.
  task automatic do_reset();
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    sbq.delete();
    tb_occ = 0;
    tb_last = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_occupancy", 32'(occupancy), 32'(0));
    chk("rst_out_mant", 32'(out_mant), 32'(0));
    chk("rst_out_exp", 32'(out_exp), 32'(0));
    chk("rst_out_sign", 32'(out_sign), 32'(0));
    chk("rst_out_src", 32'(out_src), 32'(0));
    a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("rst_ready", 32'({a_ready, b_ready}), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit is_b, input logic [27:0] m, input logic [7:0] ex,
                      input logic s, input logic [1:0] md);
    int n;
    if (is_b) begin
      b_valid = 1'b1; b_mant = m; b_exp = ex; b_sign = s; b_mode = md;
    end else begin
      a_valid = 1'b1; a_mant = m; a_exp = ex; a_sign = s; a_mode = md;
    end
    n = 0;
    while (1) begin
      @(negedge clk);
      if (is_b ? b_ready : a_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'(n), 32'(0));
        break;
      end
    end
    @(posedge clk);
    #1;
    a_valid = 1'b0; b_valid = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [22:0] m,
                            input logic [7:0] ex, input logic src);
    int n;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
      if (n > 50) begin
        chk({name, "_timeout"}, 32'(n), 32'(0));
        break;
      end
    end
    chk({name, "_mant"}, 32'(out_mant), 32'(m));
    chk({name, "_exp"}, 32'(out_exp), 32'(ex));
    chk({name, "_src"}, 32'(out_src), 32'(src));
    @(posedge clk);
    #1;
  endtask

  int n_xfer;

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Isolated operations: exact results and latency.
    out_ready = 1'b1;
    lat_chk = 1'b1;
    send(1'b0, 28'h7FFFFFF, 8'h7F, 1'b0, 2'd0);
    expect_out("s1_carry", 23'h0, 8'h80, 1'b0);
    send(1'b0, 28'h4000004, 8'h7F, 1'b0, 2'd0);
    expect_out("s2_tie_even", 23'h0, 8'h7F, 1'b0);
    send(1'b0, 28'h400000C, 8'h7F, 1'b0, 2'd0);
    expect_out("s2_tie_odd", 23'h2, 8'h7F, 1'b0);
    send(1'b0, 28'h4000004, 8'h7F, 1'b1, 2'd2);
    expect_out("s2_rup_neg", 23'h0, 8'h7F, 1'b0);
    send(1'b0, 28'h4000004, 8'h7F, 1'b1, 2'd3);
    expect_out("s2_rdn_neg", 23'h1, 8'h7F, 1'b0);
    send(1'b0, 28'h7FFFFFF, 8'hFF, 1'b0, 2'd0);
    expect_out("s5_exp_sat", 23'h0, 8'hFF, 1'b0);
    send(1'b1, 28'h7FFFFF9, 8'hFE, 1'b0, 2'd2);
    expect_out("s5_b_carry", 23'h0, 8'hFF, 1'b1);
    send(1'b1, 28'h7FFFFFF, 8'h10, 1'b0, 2'd1);
    expect_out("s5_rtz", 23'h7FFFFF, 8'h10, 1'b1);
    lat_chk = 1'b0;

    // Continuous contention: grants alternate starting with A.
    do_reset();
    out_ready = 1'b1;
    rec_on = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      a_valid = 1'b1; b_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    rec_on = 1'b0;
    chk("s3_grant_count", 32'(grant_log.size()), 32'(8));
    chk("s3_src_count", 32'(src_log.size()), 32'(8));
    for (int i = 0; i < grant_log.size(); i++) chk("s3_grant_order", 32'(grant_log[i]), 32'(i % 2));
    for (int i = 0; i < src_log.size(); i++) chk("s3_src_order", 32'(src_log[i]), 32'(i % 2));

    // Backpressure: credits run out at FIFO_DEPTH, then one grant per pop.
    out_ready = 1'b0;
    n_xfer = 0;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      a_valid = 1'b1; b_valid = 1'b1;
      @(negedge clk);
      if (a_ready || b_ready) n_xfer++;
      @(posedge clk);
      #1;
    end
    chk("s4_xfers", 32'(n_xfer), 32'(DEPTH));
    chk("s4_full_occ", 32'(occupancy), 32'(DEPTH));
    chk("s4_full_ready", 32'({a_ready, b_ready}), 32'(0));
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      rand_ops();
      @(posedge clk);
      #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("s4_drained", 32'(sbq.size()), 32'(0));
    chk("s4_occ_zero", 32'(occupancy), 32'(0));

    // Reset with two results in flight and two buffered.
    out_ready = 1'b0;
    n_xfer = 0;
    for (int i = 0; i < 40 && n_xfer < 4; i++) begin
      rand_ops();
      a_valid = 1'b1; b_valid = 1'b1;
      @(negedge clk);
      if (a_ready || b_ready) n_xfer++;
      @(posedge clk);
      #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    chk("s6_xfers", 32'(n_xfer), 32'(4));
    chk("s6_pre_occ", 32'(occupancy), 32'(4));
    chk("s6_pre_valid", 32'(out_valid), 32'(1));
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("s6_post_valid", 32'(out_valid), 32'(0));
    end
    @(posedge clk);
    #1;

    // Random traffic with random backpressure.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      a_valid   = ($urandom_range(2) != 0);
      b_valid   = ($urandom_range(2) != 0);
      out_ready = ($urandom_range(3) != 0);
      @(posedge clk);
      #1;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    out_ready = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("rand_drained", 32'(sbq.size()), 32'(0));
    chk("rand_occ_zero", 32'(occupancy), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
